// File: rtl/ssram_bank.sv
// ----------------------------------------------------------------------------
// ssram_bank
//   Register bank for the HWAG configuration/status space. DEPTH registers of
//   WIDTH bits are reachable through a single-cycle bus port (binary address),
//   drive parallel outputs and can be loaded by fabric logic via hw_ld/hw_d.
//   Each register has its own reset value. Registers flagged in RO_MASK reject
//   bus writes, but hw_ld can still load them.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   bus_addr   register index
//   bus_wdata  write data
//   bus_we     write strobe (one cycle per access)
//   bus_re     read strobe (one cycle per access)
//   bus_rdata  read data, valid with bus_ack, 0 otherwise
//   bus_ack    one-cycle completion pulse, one cycle after the access
//   bus_err    access rejected (bad address or write to a read-only register)
//   hw_ld      per-register hardware load strobes
//   hw_d       hardware load data, register i = hw_d[i*WIDTH +: WIDTH]
//   out        parallel register contents, same packing as hw_d
//   wr_stb     bit i pulses with bus_ack after a successful bus write to i
// ----------------------------------------------------------------------------
module ssram_bank #(
    parameter int                       WIDTH     = 16,
    parameter int                       DEPTH     = 16,
    parameter int                       ADDR_W    = 8,
    parameter logic [DEPTH*WIDTH-1:0]   RESET_VAL = '0,
    parameter logic [DEPTH-1:0]         RO_MASK   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [WIDTH-1:0]         bus_wdata,
    input  logic                     bus_we,
    input  logic                     bus_re,
    output logic [WIDTH-1:0]         bus_rdata,
    output logic                     bus_ack,
    output logic                     bus_err,
    input  logic [DEPTH-1:0]         hw_ld,
    input  logic [DEPTH*WIDTH-1:0]   hw_d,
    output logic [DEPTH*WIDTH-1:0]   out,
    output logic [DEPTH-1:0]         wr_stb
);

    logic [WIDTH-1:0] regs [DEPTH];

    logic             access;
    logic             addr_ok;
    logic             ro_hit;
    logic             acc_err;
    logic             wr_ok;
    logic [WIDTH-1:0] rd_val;
    logic [DEPTH-1:0] wr_sel;

    // Address decode by comparison against each index, so an out-of-range
    // address simply matches nothing (rd_val stays 0, addr_ok stays 0).
    always_comb begin
        addr_ok = 1'b0;
        ro_hit  = 1'b0;
        rd_val  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus_addr == ADDR_W'(i)) begin
                addr_ok = 1'b1;
                ro_hit  = RO_MASK[i];
                rd_val  = regs[i];
            end
        end
        access  = bus_we | bus_re;
        acc_err = access & (~addr_ok | (bus_we & ro_hit));
        wr_ok   = bus_we & addr_ok & ~ro_hit;
        wr_sel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i] = wr_ok & (bus_addr == ADDR_W'(i));
        end
    end

    // A successful bus write takes priority over hw_ld on the same register;
    // a rejected write leaves wr_sel clear, so hw_ld wins on read-only ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL[i*WIDTH +: WIDTH];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= bus_wdata;
                end else if (hw_ld[i]) begin
                    regs[i] <= hw_d[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Response stage. rd_val is taken before this edge's updates, so a
    // combined we+re returns the pre-write value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            wr_stb    <= '0;
        end else begin
            bus_ack   <= access;
            bus_err   <= acc_err;
            bus_rdata <= (bus_re & ~acc_err) ? rd_val : '0;
            wr_stb    <= wr_sel;
        end
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            out[i*WIDTH +: WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_ssram_bank.sv
// ----------------------------------------------------------------------------
// tb_ssram_bank
//   Directed bench for ssram_bank (WIDTH=16, DEPTH=16, ADDR_W=8, register 5
//   read-only). Inputs change on the falling edge; outputs are checked on the
//   following falling edge, i.e. half a cycle after the edge that produced them.
// ----------------------------------------------------------------------------
module tb_ssram_bank;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 8;
    localparam int VW     = DEPTH * WIDTH;

    localparam logic [VW-1:0] RV =
        {192'h0, 16'hA5A5, 16'h0022, 16'h0011, 16'h0F00};
    localparam logic [DEPTH-1:0] RO = 16'h0020;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] bus_addr;
    logic [WIDTH-1:0]  bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [WIDTH-1:0]  bus_rdata;
    logic              bus_ack;
    logic              bus_err;
    logic [DEPTH-1:0]  hw_ld;
    logic [VW-1:0]     hw_d;
    logic [VW-1:0]     out;
    logic [DEPTH-1:0]  wr_stb;

    int total;
    int bad;

    logic [VW-1:0] exp_img;

    ssram_bank #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RV),
        .RO_MASK   (RO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .hw_ld     (hw_ld),
        .hw_d      (hw_d),
        .out       (out),
        .wr_stb    (wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] slice(input logic [VW-1:0] v,
                                               input int i);
        return v[i*WIDTH +: WIDTH];
    endfunction

    task automatic idle();
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        hw_ld     = '0;
        hw_d      = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_img = RV;
        idle();
        rst = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_ack",   VW'(bus_ack),   VW'(1'b0));
        chk("rst_err",   VW'(bus_err),   VW'(1'b0));
        chk("rst_rdata", VW'(bus_rdata), VW'(16'h0));
        chk("rst_wrstb", VW'(wr_stb),    VW'(16'h0));
        chk("rst_out",   out,            RV);
        rst = 1'b1;
        step();

        // 1: read reset value of reg 3
        bus_re = 1'b1; bus_addr = 8'd3;
        step();
        chk("t1_ack",   VW'(bus_ack),   VW'(1'b1));
        chk("t1_rdata", VW'(bus_rdata), VW'(16'hA5A5));
        chk("t1_err",   VW'(bus_err),   VW'(1'b0));

        // 2: write reg 2 then read it back-to-back
        idle();
        bus_we = 1'b1; bus_addr = 8'd2; bus_wdata = 16'h1234;
        exp_img[2*WIDTH +: WIDTH] = 16'h1234;
        step();
        chk("t2_wack",   VW'(bus_ack),   VW'(1'b1));
        chk("t2_werr",   VW'(bus_err),   VW'(1'b0));
        chk("t2_wstb",   VW'(wr_stb),    VW'(16'h0004));
        chk("t2_wrdata", VW'(bus_rdata), VW'(16'h0));
        idle();
        bus_re = 1'b1; bus_addr = 8'd2;
        step();
        chk("t2_rack",   VW'(bus_ack),       VW'(1'b1));
        chk("t2_rdata",  VW'(bus_rdata),     VW'(16'h1234));
        chk("t2_rstb",   VW'(wr_stb),        VW'(16'h0));
        chk("t2_out2",   VW'(slice(out, 2)), VW'(16'h1234));
        idle();
        step();
        chk("t2_noack",  VW'(bus_ack),   VW'(1'b0));
        chk("t2_idle_rd", VW'(bus_rdata), VW'(16'h0));

        // 3: out-of-range read and write
        bus_re = 1'b1; bus_addr = 8'd16;
        step();
        chk("t3_rack",   VW'(bus_ack),   VW'(1'b1));
        chk("t3_rerr",   VW'(bus_err),   VW'(1'b1));
        chk("t3_rdata",  VW'(bus_rdata), VW'(16'h0));
        idle();
        bus_we = 1'b1; bus_addr = 8'd16; bus_wdata = 16'hFFFF;
        step();
        chk("t3_wack",   VW'(bus_ack),   VW'(1'b1));
        chk("t3_werr",   VW'(bus_err),   VW'(1'b1));
        chk("t3_wstb",   VW'(wr_stb),    VW'(16'h0));
        chk("t3_img",    out,            exp_img);

        // 4: read-only register 5
        idle();
        bus_we = 1'b1; bus_addr = 8'd5; bus_wdata = 16'hFFFF;
        step();
        chk("t4_wack",   VW'(bus_ack),       VW'(1'b1));
        chk("t4_werr",   VW'(bus_err),       VW'(1'b1));
        chk("t4_wstb",   VW'(wr_stb),        VW'(16'h0));
        chk("t4_out5",   VW'(slice(out, 5)), VW'(16'h0));
        idle();
        hw_ld[5] = 1'b1; hw_d[5*WIDTH +: WIDTH] = 16'h0042;
        exp_img[5*WIDTH +: WIDTH] = 16'h0042;
        step();
        chk("t4_hwack",  VW'(bus_ack),   VW'(1'b0));
        idle();
        bus_re = 1'b1; bus_addr = 8'd5;
        step();
        chk("t4_rack",   VW'(bus_ack),   VW'(1'b1));
        chk("t4_rerr",   VW'(bus_err),   VW'(1'b0));
        chk("t4_rdata",  VW'(bus_rdata), VW'(16'h0042));

        // RO collision: hw_ld wins, access errors
        idle();
        bus_we = 1'b1; bus_addr = 8'd5; bus_wdata = 16'h1111;
        hw_ld[5] = 1'b1; hw_d[5*WIDTH +: WIDTH] = 16'h0077;
        exp_img[5*WIDTH +: WIDTH] = 16'h0077;
        step();
        chk("t4_cerr",   VW'(bus_err),       VW'(1'b1));
        chk("t4_cout5",  VW'(slice(out, 5)), VW'(16'h0077));

        // 5: bus write beats hw_ld, then combined we+re
        idle();
        bus_we = 1'b1; bus_addr = 8'd1; bus_wdata = 16'h0001;
        hw_ld[1] = 1'b1; hw_d[1*WIDTH +: WIDTH] = 16'h0002;
        hw_ld[0] = 1'b1; hw_d[0*WIDTH +: WIDTH] = 16'h0F0F;
        exp_img[1*WIDTH +: WIDTH] = 16'h0001;
        exp_img[0*WIDTH +: WIDTH] = 16'h0F0F;
        step();
        chk("t5_ack",    VW'(bus_ack),       VW'(1'b1));
        chk("t5_err",    VW'(bus_err),       VW'(1'b0));
        chk("t5_wstb",   VW'(wr_stb),        VW'(16'h0002));
        chk("t5_out1",   VW'(slice(out, 1)), VW'(16'h0001));
        chk("t5_out0",   VW'(slice(out, 0)), VW'(16'h0F0F));
        idle();
        bus_we = 1'b1; bus_re = 1'b1; bus_addr = 8'd1; bus_wdata = 16'h0009;
        exp_img[1*WIDTH +: WIDTH] = 16'h0009;
        step();
        chk("t5_wr_ack",   VW'(bus_ack),   VW'(1'b1));
        chk("t5_wr_rdata", VW'(bus_rdata), VW'(16'h0001));
        chk("t5_wr_stb",   VW'(wr_stb),    VW'(16'h0002));
        idle();
        bus_re = 1'b1; bus_addr = 8'd1;
        step();
        chk("t5_rd_rdata", VW'(bus_rdata), VW'(16'h0009));
        chk("t5_img",      out,            exp_img);

        // 6: four back-to-back reads, one ack each with matching data
        for (int a = 0; a < 4; a++) begin
            idle();
            bus_re = 1'b1; bus_addr = ADDR_W'(a);
            step();
            chk($sformatf("t6_ack%0d", a),   VW'(bus_ack),   VW'(1'b1));
            chk($sformatf("t6_rdata%0d", a), VW'(bus_rdata),
                VW'(slice(exp_img, a)));
        end
        idle();
        step();

        // Reset dropped during the 2nd read of a burst
        bus_re = 1'b1; bus_addr = 8'd0;
        step();
        chk("t6r_ack0",  VW'(bus_ack),   VW'(1'b1));
        bus_addr = 8'd1;
        #2 rst = 1'b0;
        #1;
        chk("t6r_async", VW'(bus_ack),   VW'(1'b0));
        step();
        idle();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("t6r_noack%0d", c), VW'(bus_ack), VW'(1'b0));
        end
        chk("t6r_img", out, RV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
